// File: rtl/wr_gray_sync.sv
// rtl/wr_gray_sync.sv - write-domain read-pointer synchronizer with occupancy, full and Gray-error tracking
//
// Brings the read-domain Gray pointer into wr_clk through a SYNC_STAGES flop
// chain, converts it to binary, and derives registered occupancy, full and
// almost_full flags against the write logic's next binary pointer. It also
// watches the synchronized pointer for multi-bit steps or impossible
// occupancy and reports them through a sticky flag and a saturating counter.
//
// Ports:
//   wr_clk       in   write-domain clock, rising edge
//   wr_rst       in   asynchronous active-low reset
//   rd_gray_in   in   Gray read pointer from the read domain (asynchronous)
//   wr_bin_nxt   in   binary write pointer loaded at this edge
//   clr_err      in   synchronous clear of gray_err / err_cnt
//   rd_gray_sync out  last synchronizer stage
//   rd_bin_sync  out  registered binary form of rd_gray_sync
//   fill_level   out  registered occupancy, 0..DEPTH
//   full         out  registered full flag
//   almost_full  out  registered fill_level >= AF_THRESH
//   gray_err     out  sticky protocol-error flag
//   err_cnt      out  saturating error counter

module wr_gray_sync #(
    parameter int ADD_WIDTH   = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 2**ADD_WIDTH - 2
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst,
    input  logic [ADD_WIDTH:0]   rd_gray_in,
    input  logic [ADD_WIDTH:0]   wr_bin_nxt,
    input  logic                 clr_err,
    output logic [ADD_WIDTH:0]   rd_gray_sync,
    output logic [ADD_WIDTH:0]   rd_bin_sync,
    output logic [ADD_WIDTH:0]   fill_level,
    output logic                 full,
    output logic                 almost_full,
    output logic                 gray_err,
    output logic [7:0]           err_cnt
);

    localparam int PW    = ADD_WIDTH + 1;
    localparam int DEPTH = 2**ADD_WIDTH;
    localparam logic [ADD_WIDTH:0] DEPTH_V = PW'(DEPTH);
    localparam logic [ADD_WIDTH:0] AF_V    = PW'(AF_THRESH);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
            $error("wr_gray_sync: SYNC_STAGES must be in 2..4");
        end
        if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af_thresh
            $error("wr_gray_sync: AF_THRESH must be in 1..DEPTH");
        end
    endgenerate

    function automatic logic [ADD_WIDTH:0] gray2bin(input logic [ADD_WIDTH:0] g);
        logic [ADD_WIDTH:0] b;
        b[ADD_WIDTH] = g[ADD_WIDTH];
        for (int i = ADD_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADD_WIDTH:0] sync_q [SYNC_STAGES];
    logic [ADD_WIDTH:0] sync_d [SYNC_STAGES];
    logic [ADD_WIDTH:0] prev_q, prev_d;
    logic [ADD_WIDTH:0] rd_bin_q, rd_bin_d;
    logic [ADD_WIDTH:0] fill_q, fill_d;
    logic               full_q, full_d;
    logic               af_q, af_d;
    logic               gray_err_q, gray_err_d;
    logic [7:0]         err_cnt_q, err_cnt_d;

    logic [ADD_WIDTH:0] gray_now;
    logic [ADD_WIDTH:0] gray_diff;
    logic [ADD_WIDTH:0] occ;
    logic               multi_bit;
    logic               occ_err;
    logic               err_evt;

    always_comb begin
        sync_d[0] = rd_gray_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        gray_now  = sync_q[SYNC_STAGES-1];
        gray_diff = gray_now ^ prev_q;
        // Clearing the lowest set bit leaves a nonzero value only when two or
        // more bits changed, i.e. Hamming distance > 1.
        multi_bit = (gray_diff & (gray_diff - 1'b1)) != '0;

        // Wrap-around falls out of the modulo-2**PW subtraction.
        occ     = wr_bin_nxt - rd_bin_q;
        occ_err = occ > DEPTH_V;
        err_evt = multi_bit | occ_err;

        prev_d   = gray_now;
        rd_bin_d = gray2bin(gray_now);
        fill_d   = occ;
        full_d   = (wr_bin_nxt[ADD_WIDTH] != rd_bin_q[ADD_WIDTH]) &&
                   (wr_bin_nxt[ADD_WIDTH-1:0] == rd_bin_q[ADD_WIDTH-1:0]);
        af_d     = full_d | (occ >= AF_V);

        gray_err_d = gray_err_q;
        err_cnt_d  = err_cnt_q;
        if (err_evt) begin
            // A fresh error outranks a simultaneous clear: the clear wipes
            // history, then this event is counted as the first one.
            gray_err_d = 1'b1;
            if (clr_err) begin
                err_cnt_d = 8'd1;
            end else if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end else if (clr_err) begin
            gray_err_d = 1'b0;
            err_cnt_d  = 8'd0;
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q     <= '0;
            rd_bin_q   <= '0;
            fill_q     <= '0;
            full_q     <= 1'b0;
            af_q       <= 1'b0;
            gray_err_q <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            prev_q     <= prev_d;
            rd_bin_q   <= rd_bin_d;
            fill_q     <= fill_d;
            full_q     <= full_d;
            af_q       <= af_d;
            gray_err_q <= gray_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign rd_gray_sync = sync_q[SYNC_STAGES-1];
    assign rd_bin_sync  = rd_bin_q;
    assign fill_level   = fill_q;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign gray_err     = gray_err_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_wr_gray_sync.sv
// tb/tb_wr_gray_sync.sv - directed scoreboard bench for wr_gray_sync

module tb_wr_gray_sync;

    logic       wr_clk;
    logic       wr_rst;
    logic [3:0] rd_gray_in;
    logic [3:0] wr_bin_nxt;
    logic       clr_err;

    logic [3:0] s2_gray, s2_bin, s2_fill;
    logic       s2_full, s2_af, s2_gerr;
    logic [7:0] s2_cnt;
    logic [3:0] s3_gray, s3_bin, s3_fill;
    logic       s3_full, s3_af, s3_gerr;
    logic [7:0] s3_cnt;

    int checks = 0;
    int errors = 0;

    localparam int S2_GRAY = 0, S2_BIN = 1, S2_FILL = 2, S2_FULL = 3, S2_AF = 4,
                   S2_GERR = 5, S2_CNT = 6, S3_GRAY = 7, S3_BIN = 8, S3_FILL = 9,
                   S3_FULL = 10, S3_AF = 11, S3_GERR = 12, S3_CNT = 13;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] exp;
    } exp_t;

    exp_t sb_q[$];

    wr_gray_sync #(.ADD_WIDTH(3), .SYNC_STAGES(2), .AF_THRESH(6)) u_s2 (
        .wr_clk(wr_clk), .wr_rst(wr_rst), .rd_gray_in(rd_gray_in),
        .wr_bin_nxt(wr_bin_nxt), .clr_err(clr_err),
        .rd_gray_sync(s2_gray), .rd_bin_sync(s2_bin), .fill_level(s2_fill),
        .full(s2_full), .almost_full(s2_af), .gray_err(s2_gerr), .err_cnt(s2_cnt)
    );

    wr_gray_sync #(.ADD_WIDTH(3), .SYNC_STAGES(3), .AF_THRESH(6)) u_s3 (
        .wr_clk(wr_clk), .wr_rst(wr_rst), .rd_gray_in(rd_gray_in),
        .wr_bin_nxt(wr_bin_nxt), .clr_err(clr_err),
        .rd_gray_sync(s3_gray), .rd_bin_sync(s3_bin), .fill_level(s3_fill),
        .full(s3_full), .almost_full(s3_af), .gray_err(s3_gerr), .err_cnt(s3_cnt)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    function automatic logic [7:0] get_obs(input int sel);
        case (sel)
            S2_GRAY: return {4'h0, s2_gray};
            S2_BIN:  return {4'h0, s2_bin};
            S2_FILL: return {4'h0, s2_fill};
            S2_FULL: return {7'h0, s2_full};
            S2_AF:   return {7'h0, s2_af};
            S2_GERR: return {7'h0, s2_gerr};
            S2_CNT:  return s2_cnt;
            S3_GRAY: return {4'h0, s3_gray};
            S3_BIN:  return {4'h0, s3_bin};
            S3_FILL: return {4'h0, s3_fill};
            S3_FULL: return {7'h0, s3_full};
            S3_AF:   return {7'h0, s3_af};
            S3_GERR: return {7'h0, s3_gerr};
            default: return s3_cnt;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [7:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t       e;
        logic [7:0] obs;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = get_obs(e.sel);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic tick_check();
        tick();
        drain();
    endtask

    logic [3:0] walk1 [8];
    logic [3:0] walk2 [3];

    initial begin
        walk1[0] = 4'b0001; walk1[1] = 4'b0011; walk1[2] = 4'b0010; walk1[3] = 4'b0110;
        walk1[4] = 4'b0111; walk1[5] = 4'b0101; walk1[6] = 4'b0100; walk1[7] = 4'b1100;
        walk2[0] = 4'b1101; walk2[1] = 4'b1111; walk2[2] = 4'b1110;

        wr_rst     = 1'b0;
        rd_gray_in = 4'h0;
        wr_bin_nxt = 4'h0;
        clr_err    = 1'b0;

        // Power-on reset, before any clock edge
        #2;
        push("por_gray", S2_GRAY, 8'h0);
        push("por_bin", S2_BIN, 8'h0);
        push("por_fill", S2_FILL, 8'h0);
        push("por_cnt", S2_CNT, 8'h0);
        drain();
        tick();
        wr_rst = 1'b1;
        tick();

        // Latency: SYNC_STAGES=2 vs 3
        rd_gray_in = 4'b0001;
        wr_bin_nxt = 4'b0001;
        push("lat_e0_s2_gray", S2_GRAY, 8'h0);
        push("lat_e0_s3_gray", S3_GRAY, 8'h0);
        tick_check();
        push("lat_e1_s2_gray", S2_GRAY, 8'h1);
        push("lat_e1_s2_bin", S2_BIN, 8'h0);
        push("lat_e1_s3_gray", S3_GRAY, 8'h0);
        tick_check();
        push("lat_e2_s2_bin", S2_BIN, 8'h1);
        push("lat_e2_s3_gray", S3_GRAY, 8'h1);
        push("lat_e2_s3_bin", S3_BIN, 8'h0);
        tick_check();
        push("lat_e3_s3_bin", S3_BIN, 8'h1);
        push("lat_e3_s2_fill", S2_FILL, 8'h0);
        push("lat_e3_s2_gerr", S2_GERR, 8'h0);
        tick_check();

        // Return read pointer to zero with a single-bit step
        rd_gray_in = 4'b0000;
        repeat (3) tick();

        // Full: rd_bin_sync=0000, wr_bin_nxt=1000
        wr_bin_nxt = 4'b1000;
        push("full_flag", S2_FULL, 8'h1);
        push("full_fill", S2_FILL, 8'h8);
        push("full_af", S2_AF, 8'h1);
        push("full_cnt", S2_CNT, 8'h0);
        tick_check();

        // Walk read pointer one Gray step at a time up to 1100 (binary 1000)
        for (int i = 0; i < 8; i++) begin
            rd_gray_in = walk1[i];
            tick();
        end
        repeat (3) tick();
        push("wrap_gray", S2_GRAY, 8'hC);
        push("wrap_bin", S2_BIN, 8'h8);
        push("wrap_full", S2_FULL, 8'h0);
        push("wrap_fill", S2_FILL, 8'h0);
        push("wrap_af", S2_AF, 8'h0);
        push("walk_gerr", S2_GERR, 8'h0);
        push("walk_cnt", S2_CNT, 8'h0);
        tick_check();

        // Walk to binary 1011, then write pointer 0010 wraps past it
        wr_bin_nxt = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            rd_gray_in = walk2[i];
            tick();
        end
        repeat (3) tick();
        wr_bin_nxt = 4'b0010;
        push("wrap2_bin", S2_BIN, 8'hB);
        push("wrap2_fill", S2_FILL, 8'h7);
        push("wrap2_full", S2_FULL, 8'h0);
        push("wrap2_af", S2_AF, 8'h1);
        push("wrap2_gerr", S2_GERR, 8'h0);
        tick_check();

        // Almost-full threshold and full across the wrap
        wr_bin_nxt = 4'b0000;
        push("af5_fill", S2_FILL, 8'h5);
        push("af5_af", S2_AF, 8'h0);
        tick_check();
        wr_bin_nxt = 4'b0001;
        push("af6_fill", S2_FILL, 8'h6);
        push("af6_af", S2_AF, 8'h1);
        push("af6_full", S2_FULL, 8'h0);
        tick_check();
        wr_bin_nxt = 4'b0011;
        push("af8_fill", S2_FILL, 8'h8);
        push("af8_full", S2_FULL, 8'h1);
        push("af8_af", S2_AF, 8'h1);
        tick_check();
        wr_bin_nxt = 4'b1011;
        tick();

        // Two-bit Gray jump 1110 -> 1101
        rd_gray_in = 4'b1101;
        tick();
        push("jump_gray", S2_GRAY, 8'hD);
        push("jump_gerr_pre", S2_GERR, 8'h0);
        tick_check();
        push("jump_gerr", S2_GERR, 8'h1);
        push("jump_cnt", S2_CNT, 8'h1);
        tick_check();

        // fill=5 with gray_err=1, a value in flight, then reset between edges
        wr_bin_nxt = 4'b1110;
        rd_gray_in = 4'b1111;
        push("pre_rst_fill", S2_FILL, 8'h5);
        push("pre_rst_gerr", S2_GERR, 8'h1);
        tick_check();
        #3;
        wr_rst = 1'b0;
        #1;
        push("rst_s2_gray", S2_GRAY, 8'h0);
        push("rst_s2_bin", S2_BIN, 8'h0);
        push("rst_s2_fill", S2_FILL, 8'h0);
        push("rst_s2_full", S2_FULL, 8'h0);
        push("rst_s2_af", S2_AF, 8'h0);
        push("rst_s2_gerr", S2_GERR, 8'h0);
        push("rst_s2_cnt", S2_CNT, 8'h0);
        push("rst_s3_gray", S3_GRAY, 8'h0);
        push("rst_s3_bin", S3_BIN, 8'h0);
        push("rst_s3_fill", S3_FILL, 8'h0);
        push("rst_s3_full", S3_FULL, 8'h0);
        push("rst_s3_af", S3_AF, 8'h0);
        push("rst_s3_gerr", S3_GERR, 8'h0);
        push("rst_s3_cnt", S3_CNT, 8'h0);
        drain();
        tick();
        tick();
        rd_gray_in = 4'b0000;
        wr_bin_nxt = 4'b0000;
        wr_rst     = 1'b1;
        push("post_rst1_gray", S2_GRAY, 8'h0);
        push("post_rst1_gerr", S2_GERR, 8'h0);
        push("post_rst1_cnt", S2_CNT, 8'h0);
        tick_check();
        push("post_rst2_gray", S2_GRAY, 8'h0);
        push("post_rst2_gerr", S2_GERR, 8'h0);
        push("post_rst2_fill", S2_FILL, 8'h0);
        tick_check();

        // Gray error 0000 -> 0011, then saturation
        wr_bin_nxt = 4'b0010;
        rd_gray_in = 4'b0011;
        tick();
        push("gerr_gray", S2_GRAY, 8'h3);
        push("gerr_pre", S2_GERR, 8'h0);
        tick_check();
        push("gerr_flag", S2_GERR, 8'h1);
        push("gerr_cnt1", S2_CNT, 8'h1);
        tick_check();
        for (int i = 0; i < 300; i++) begin
            rd_gray_in = (i % 2 == 0) ? 4'b0000 : 4'b0011;
            tick();
        end
        rd_gray_in = 4'b0000;
        repeat (3) tick();
        push("sat_cnt", S2_CNT, 8'hFF);
        push("sat_gerr", S2_GERR, 8'h1);
        tick_check();

        // Clear racing a new violation, then a lone clear
        rd_gray_in = 4'b0011;
        tick();
        tick();
        clr_err = 1'b1;
        push("race_gerr", S2_GERR, 8'h1);
        push("race_cnt", S2_CNT, 8'h1);
        tick_check();
        push("clr_gerr", S2_GERR, 8'h0);
        push("clr_cnt", S2_CNT, 8'h0);
        tick_check();
        clr_err = 1'b0;
        push("idle_gerr", S2_GERR, 8'h0);
        push("idle_cnt", S2_CNT, 8'h0);
        tick_check();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
